// File: rtl/gradient_filter.sv
// Streaming 3x3 gradient filter: Sobel, Prewitt, Scharr or pass-through.
// Define GRAD_THRESH_EN to binarise the gradient magnitude against threshold.
module gradient_filter #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 720,
  parameter int IMAGE_HEIGHT = 540
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_empty,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic                  read_fifo,
  input  logic                  output_full,
  output logic                  write_fifo,
  output logic [DATA_WIDTH-1:0] pixel_out,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  frame_done
);

  localparam int DW   = DATA_WIDTH;
  localparam int W    = IMAGE_WIDTH;
  localparam int H    = IMAGE_HEIGHT;
  localparam int GW   = DW + 5;
  localparam int NPIX = W * H;
  localparam int CW   = $clog2(NPIX + W + 1);
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int CL   = 2 * W + 3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          advance;
  logic          step;
  logic          emit;
  logic          last_step;
  logic          border;
  logic [CW-1:0] in_cnt;
  logic [XW-1:0] cc;
  logic [YW-1:0] cr;
  logic [1:0]    mode_q;
  logic [DW-1:0] chain [CL];

  logic          s0_valid;
  logic          s0_border;
  logic          s0_last;

  logic                 s1_valid;
  logic                 s1_border;
  logic                 s1_last;
  logic [1:0]           s1_mode;
  logic [DW-1:0]        s1_ctr;
  logic signed [GW-1:0] s1_gx;
  logic signed [GW-1:0] s1_gy;

  logic          out_valid;
  logic          out_last;

`ifdef GRAD_THRESH_EN
  logic [DW-1:0] thr_q;
  logic [DW-1:0] s1_thr;
`else
  logic unused_thr;
  assign unused_thr = ^threshold;
`endif

  function automatic logic signed [GW-1:0] ext(
    input logic [DW-1:0] d
  );
    ext = $signed({{(GW-DW){1'b0}}, d});
  endfunction

  // Side taps weigh (1,1,3), centre taps (2,1,10) for Sobel/Prewitt/Scharr.
  function automatic logic signed [GW-1:0] wt(
    input logic signed [GW-1:0] d,
    input logic [1:0]           m,
    input logic                 ctr
  );
    case (m)
      2'd0:    wt = ctr ? (d <<< 1) : d;
      2'd2:    wt = ctr ? (d <<< 3) + (d <<< 1)
                        : (d <<< 1) + d;
      default: wt = d;
    endcase
  endfunction

  always_comb begin
    advance   = !output_full;
    read_fifo = rst && advance && !input_empty
                && (state != FLUSH);
    step      = read_fifo
                || (rst && advance && state == FLUSH);
    emit      = step && (state != FILL);
    last_step = (state == FLUSH)
                && (in_cnt == CW'(NPIX + W));
    border    = (cr == '0) || (cr == YW'(H - 1))
                || (cc == '0) || (cc == XW'(W - 1));
    state_nxt = state;
    unique case (state)
      FILL:
        if (read_fifo && in_cnt == CW'(W))
          state_nxt = RUN;
      RUN:
        if (read_fifo && in_cnt == CW'(NPIX - 1))
          state_nxt = FLUSH;
      FLUSH:
        if (step && last_step)
          state_nxt = FILL;
      default:
        state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (step) begin
      chain[0] <= read_fifo ? gray_in : '0;
      for (int i = 1; i < CL; i++)
        chain[i] <= chain[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_cnt    <= '0;
      cc        <= '0;
      cr        <= '0;
      mode_q    <= '0;
      s0_valid  <= 1'b0;
      s0_border <= 1'b0;
      s0_last   <= 1'b0;
`ifdef GRAD_THRESH_EN
      thr_q     <= '0;
`endif
    end else if (advance) begin
      s0_valid  <= emit;
      s0_border <= border;
      s0_last   <= emit && last_step;
      if (step)
        in_cnt <= last_step ? '0 : in_cnt + 1'b1;
      if (read_fifo && in_cnt == '0) begin
        mode_q <= mode;
`ifdef GRAD_THRESH_EN
        thr_q  <= threshold;
`endif
      end
      if (emit) begin
        if (last_step) begin
          cc <= '0;
          cr <= '0;
        end else if (cc == XW'(W - 1)) begin
          cc <= '0;
          cr <= cr + 1'b1;
        end else begin
          cc <= cc + 1'b1;
        end
      end
    end
  end

  logic signed [GW-1:0] tl, tc, tr;
  logic signed [GW-1:0] ml, mr;
  logic signed [GW-1:0] bl, bc, br;
  logic signed [GW-1:0] gx, gy;

  always_comb begin
    tl = ext(chain[2*W+2]);
    tc = ext(chain[2*W+1]);
    tr = ext(chain[2*W]);
    ml = ext(chain[W+2]);
    mr = ext(chain[W]);
    bl = ext(chain[2]);
    bc = ext(chain[1]);
    br = ext(chain[0]);
    gx = wt(tr - tl, mode_q, 1'b0)
       + wt(mr - ml, mode_q, 1'b1)
       + wt(br - bl, mode_q, 1'b0);
    gy = wt(bl - tl, mode_q, 1'b0)
       + wt(bc - tc, mode_q, 1'b1)
       + wt(br - tr, mode_q, 1'b0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= '0;
      s1_ctr    <= '0;
      s1_gx     <= '0;
      s1_gy     <= '0;
`ifdef GRAD_THRESH_EN
      s1_thr    <= '0;
`endif
    end else if (advance) begin
      s1_valid  <= s0_valid;
      s1_border <= s0_border;
      s1_last   <= s0_last;
      s1_mode   <= mode_q;
      s1_ctr    <= chain[W+1];
      s1_gx     <= gx;
      s1_gy     <= gy;
`ifdef GRAD_THRESH_EN
      s1_thr    <= thr_q;
`endif
    end
  end

  logic [GW-1:0] ax, ay;
  logic [GW:0]   mag, shf;
  logic [DW-1:0] sat, grad, res;

  always_comb begin
    ax  = s1_gx[GW-1] ? GW'(-s1_gx) : GW'(s1_gx);
    ay  = s1_gy[GW-1] ? GW'(-s1_gy) : GW'(s1_gy);
    mag = {1'b0, ax} + {1'b0, ay};
    shf = (s1_mode == 2'd2) ? (mag >> 4) : (mag >> 1);
    sat = (|shf[GW:DW]) ? '1 : shf[DW-1:0];
`ifdef GRAD_THRESH_EN
    grad = (sat >= s1_thr) ? '1 : '0;
`else
    grad = sat;
`endif
    if (s1_mode == 2'd3) res = s1_ctr;
    else if (s1_border)  res = '0;
    else                 res = grad;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pixel_out <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid)
        pixel_out <= res;
    end
  end

  assign write_fifo = out_valid && !output_full;
  assign frame_done = write_fifo && out_last;

endmodule

// File: tb/tb_gradient_filter.sv
// Directed bench for gradient_filter on an 8x6 frame.
// Table of frame scenarios plus stall, mode-switch and reset sequences.
module tb_gradient_filter;

  localparam int DW   = 8;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int THR  = 70;
  localparam int FLAT = 0;
  localparam int STEP = 1;
  localparam int RAMP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          input_empty = 1'b1;
  logic [DW-1:0] gray_in = '0;
  logic          read_fifo;
  logic          output_full = 1'b0;
  logic          write_fifo;
  logic [DW-1:0] pixel_out;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] threshold = DW'(THR);
  logic          frame_done;

  always #5 clk = ~clk;

  gradient_filter #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .input_empty(input_empty),
    .gray_in    (gray_in),
    .read_fifo  (read_fifo),
    .output_full(output_full),
    .write_fifo (write_fifo),
    .pixel_out  (pixel_out),
    .mode       (mode),
    .threshold  (threshold),
    .frame_done (frame_done)
  );

  typedef struct {
    int         pat;
    logic [1:0] md;
    int         hot;
    int         eprob;
    int         slen;
  } vec_t;

  vec_t vecs [11];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src [NPIX];
  int outq [$];
  int src_idx, fd_n, fd_pos;
  int bad_rd, bad_wr, extra_wr;
  int eprob, stall_at, stall_len, stalled;
  int sw_at;
  logic [1:0] sw_mode;

  task automatic chk(input string nm, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic int pix(input int pat, input int idx);
    if (pat == FLAT) return 100;
    if (pat == STEP) return (idx % W >= 4) ? 40 : 0;
    return idx;
  endfunction

  function automatic int expv(input int pat,
                              input logic [1:0] md,
                              input int hot, input int idx);
    int r, c, v;
    r = idx / W;
    c = idx % W;
    if (md == 2'd3) return pix(pat, idx);
    v = 0;
    if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
      if (pat == RAMP) v = hot;
      if (pat == STEP && (c == 3 || c == 4)) v = hot;
    end
`ifdef GRAD_THRESH_EN
    v = (v >= THR) ? 255 : 0;
`endif
    return v;
  endfunction

  task automatic load(input int pat);
    for (int i = 0; i < NPIX; i++)
      src[i] = DW'(pix(pat, i));
  endtask

  task automatic sample();
    @(negedge clk);
    if (frame_done) fd_n++;
    if (write_fifo) begin
      outq.push_back(int'(pixel_out));
      if (frame_done) fd_pos = outq.size();
    end
    if (output_full && (read_fifo || write_fifo)) bad_wr++;
    if (read_fifo && src_idx >= NPIX) bad_rd++;
    if (read_fifo) src_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame();
    int cyc;
    int n;
    cyc = 0;
    src_idx = 0;
    outq.delete();
    fd_n = 0;
    fd_pos = -1;
    bad_rd = 0;
    bad_wr = 0;
    stalled = 0;
    while (outq.size() < NPIX && cyc < 400) begin
      if (sw_at >= 0 && src_idx >= sw_at) mode = sw_mode;
      input_empty = (src_idx >= NPIX)
                    || ($urandom_range(99) < eprob);
      gray_in = src[src_idx < NPIX ? src_idx : 0];
      output_full = (stall_len > 0)
                    && (outq.size() >= stall_at)
                    && (stalled < stall_len);
      if (output_full) stalled++;
      sample();
      cyc++;
    end
    input_empty = 1'b1;
    output_full = 1'b0;
    n = outq.size();
    repeat (4) sample();
    extra_wr = outq.size() - n;
  endtask

  task automatic check_frame(input string tag, input int pat,
                             input logic [1:0] md,
                             input int hot);
    chk({tag, " writes"}, outq.size(), NPIX + extra_wr);
    chk({tag, " extra"}, extra_wr, 0);
    chk({tag, " done_n"}, fd_n, 1);
    chk({tag, " done_pos"}, fd_pos, NPIX);
    chk({tag, " rd_late"}, bad_rd, 0);
    chk({tag, " io_full"}, bad_wr, 0);
    for (int i = 0; i < outq.size() && i < NPIX; i++)
      chk($sformatf("%s px%0d", tag, i), outq[i],
          expv(pat, md, hot, i));
  endtask

  initial begin
    vecs[0]  = '{FLAT, 2'd0,  0,  0,  0};
    vecs[1]  = '{STEP, 2'd0, 80,  0,  0};
    vecs[2]  = '{STEP, 2'd1, 60,  0,  0};
    vecs[3]  = '{STEP, 2'd2, 40,  0,  0};
    vecs[4]  = '{RAMP, 2'd3,  0,  0,  0};
    vecs[5]  = '{RAMP, 2'd0, 36,  0,  0};
    vecs[6]  = '{RAMP, 2'd1, 27,  0,  0};
    vecs[7]  = '{RAMP, 2'd2, 18,  0,  0};
    vecs[8]  = '{STEP, 2'd0, 80,  0, 20};
    vecs[9]  = '{STEP, 2'd0, 80, 50,  0};
    vecs[10] = '{FLAT, 2'd3,  0,  0,  0};

    eprob = 0;
    stall_at = 14;
    stall_len = 0;
    sw_at = -1;
    sw_mode = 2'd0;
    src_idx = 0;

    rst = 1'b0;
    input_empty = 1'b0;
    gray_in = 8'd55;
    repeat (3) begin
      @(negedge clk);
      chk("rst read_fifo", int'(read_fifo), 0);
      chk("rst write_fifo", int'(write_fifo), 0);
      chk("rst pixel_out", int'(pixel_out), 0);
      chk("rst frame_done", int'(frame_done), 0);
      @(posedge clk);
      #1;
    end
    input_empty = 1'b1;
    rst = 1'b1;

    for (int v = 0; v < 11; v++) begin
      load(vecs[v].pat);
      mode = vecs[v].md;
      eprob = vecs[v].eprob;
      stall_len = vecs[v].slen;
      run_frame();
      check_frame($sformatf("v%0d", v), vecs[v].pat,
                  vecs[v].md, vecs[v].hot);
    end
    eprob = 0;
    stall_len = 0;

    load(RAMP);
    mode = 2'd3;
    sw_at = 11;
    sw_mode = 2'd0;
    run_frame();
    check_frame("modesw", RAMP, 2'd3, 0);
    sw_at = -1;
    chk("modesw port", int'(mode), 0);
    run_frame();
    check_frame("nextsobel", RAMP, 2'd0, 36);

    load(RAMP);
    mode = 2'd0;
    src_idx = 0;
    for (int cyc = 0; cyc < 200 && src_idx < 20; cyc++) begin
      input_empty = 1'b0;
      gray_in = src[src_idx];
      sample();
    end
    chk("partial reads", src_idx, 20);
    rst = 1'b0;
    input_empty = 1'b0;
    @(negedge clk);
    chk("midrst read_fifo", int'(read_fifo), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    input_empty = 1'b1;
    @(negedge clk);
    chk("midrst write_fifo", int'(write_fifo), 0);
    chk("midrst pixel_out", int'(pixel_out), 0);
    @(posedge clk);
    #1;
    load(FLAT);
    run_frame();
    check_frame("afterrst", FLAT, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gradient_filter.md
# gradient_filter

Streaming 3x3 gradient/edge filter for 8-bit-class grayscale frames, placed between the grayscale-conversion FIFO and the output FIFO. It generalises the single-mode Sobel stage:
- runtime-selectable kernel (Sobel, Prewitt, Scharr, pass-through), latched per frame;
- full-throughput stall-safe pipeline;
- explicit end-of-frame flush, so a frame needs no trailing input to drain;
- frame-done status.

It produces exactly one output pixel per input pixel, in raster order.

## Interface
- DATA_WIDTH, 8: pixel width.
- IMAGE_WIDTH, 720: pixels per row, at least 3.
- IMAGE_HEIGHT, 540: rows per frame, at least 3.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- input_empty  in  1  source FIFO empty.
- gray_in  in  DATA_WIDTH  source FIFO head word (first-word-fall-through); valid while !input_empty.
- read_fifo  out  1  pops source FIFO this cycle.
- output_full  in  1  sink FIFO full.
- write_fifo  out  1  pushes pixel_out into sink FIFO this cycle.
- pixel_out  out  DATA_WIDTH  filtered pixel.
- mode  in  2  kernel select: 0 Sobel (1,2,1), 1 Prewitt (1,1,1), 2 Scharr (3,10,3), 3 pass-through.
- threshold  in  DATA_WIDTH  binarisation level; used only with GRAD_THRESH_EN.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is written.

## Operation
- Window: a shift chain of 2*IMAGE_WIDTH+3 pixels forms a 3x3 window centred on pixel (r,c).
- Sign convention:
  - gx = right column minus left column.
  - gy = bottom row minus top row.
  - Weights per selected mode.
- States:
  - FILL: reads the first IMAGE_WIDTH+1 pixels of a frame; produces no output. On the first read of a frame, mode is latched. Goes to RUN after read IMAGE_WIDTH+1.
  - RUN: each read emits one output for centre index k-(IMAGE_WIDTH+1). Goes to FLUSH after the frame's last input pixel (row H-1, col W-1).
  - FLUSH: emits IMAGE_WIDTH+1 further outputs without reading; zeros are shifted into the chain. Then frame_done fires and the state returns to FILL.
- Border pixels (row 0, row H-1, col 0, col W-1): output 0 in modes 0–2.
- Mode 3: outputs the centre pixel for every position, border included.
- Arithmetic:
  - gx and gy are signed, DATA_WIDTH+5 bits; no overflow at any mode.
  - mag = |gx|+|gy|.
  - Output for modes 0 and 1: mag>>1.
  - Output for mode 2: mag>>4.
  - Saturate to 2^DATA_WIDTH-1.
- Line buffers are not cleared at reset or between frames. Interior windows only ever see current-frame pixels, and borders are masked.
- mode changes mid-frame are ignored until the next frame's first read.

## Timing
- Pipeline: S0 window shift on read/flush step → S1 registered gx, gy, centre → S2 registered pixel_out with out_valid.
- advance = !output_full. All stages hold when advance=0.
- read_fifo = advance && !input_empty && state∈{FILL,RUN}. This is combinational; a pixel is consumed at the edge where read_fifo=1.
- FLUSH steps occur only on advance cycles.
- write_fifo = out_valid && !output_full. Combinational; pixel_out is stable while out_valid and stalled.
- Latency: a centre pixel whose window completes at edge N is presented with write_fifo in the cycle after edge N+2, given no stall.
- Throughput: 1 pixel/cycle sustained.
- Simultaneous events:
  - input_empty with output_full: nothing moves.
  - input_empty alone in RUN: bubbles propagate; out_valid drops for the corresponding cycles.
- frame_done is asserted in the same cycle as the write_fifo of the frame's final output.
- Reset values (rst=0 at an edge):
  - state=FILL; all counters, valids and frame_done = 0.
  - read_fifo=0, write_fifo=0, pixel_out=0.
  - latched mode=0.
- Reset mid-frame discards the partial frame. The next pixel read is treated as pixel (0,0).

## Configuration
- GRAD_THRESH_EN defined:
  - Modes 0–2: pixel_out = (saturated magnitude >= threshold) ? all-ones : 0.
  - threshold is sampled with mode at frame start.
  - Mode 3 is unaffected.
- GRAD_THRESH_EN undefined: the threshold port exists but is ignored; output is the saturated magnitude.

## Test plan
All scenarios use IMAGE_WIDTH=8, IMAGE_HEIGHT=6; each frame is 48 pixels.

- Flat frame of 100, mode 0 → 48 writes, all 0; frame_done pulses once, on write 48.
- Vertical step (cols 0–3 = 0, cols 4–7 = 40) → interior pixels at cols 3 and 4 are 80 / 60 / 40 for modes 0 / 1 / 2; all other pixels are 0. With GRAD_THRESH_EN and threshold 70 in mode 0: those pixels are 255, the rest 0.
- Mode 3 with ramp pixel=index → output is 0..47 in order. Assert mode=0 after pixel 10: the rest of the frame is still pass-through; the next frame uses Sobel.
- Step frame in mode 0, output_full high for 20 cycles starting at write 15 → no write_fifo while full, read_fifo stops within 3 cycles, no pixel lost or duplicated; the 48 outputs match the unstalled run.
- Step frame in mode 0 with input_empty toggled pseudo-randomly (50%) → output sequence identical to the unstalled case; FLUSH completes with input_empty held high after the last pixel.
- rst low for 1 cycle after 20 pixels are read, then a flat-100 frame in mode 0 → exactly 48 writes, all 0, and one frame_done.
